// File: rtl/quad_word_serializer_if.sv
// quad_word_serializer_if
//   Bundles the upstream word inputs, the load/busy control pair, the
//   downstream valid/ready beat stream and the frame status outputs of
//   quad_word_serializer.
//   Parameters: WIDTH (input word width), OUT_W (beat width).
//   Modports:
//     slave  - the serializer: samples in_a..in_d, load, out_ready and
//              drives busy, out_data, out_valid, out_last, checksum, done,
//              frame_count.
//     master - the surrounding environment (producer plus consumer), the
//              mirror image of slave.
interface quad_word_serializer_if #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 8
);
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_d;
  logic             load;
  logic             busy;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [WIDTH-1:0] checksum;
  logic             done;
  logic [15:0]      frame_count;

  modport slave (
    input  in_a, in_b, in_c, in_d, load, out_ready,
    output busy, out_data, out_valid, out_last, checksum, done, frame_count
  );

  modport master (
    output in_a, in_b, in_c, in_d, load, out_ready,
    input  busy, out_data, out_valid, out_last, checksum, done, frame_count
  );
endinterface

// File: rtl/quad_word_serializer.sv
// quad_word_serializer
//   Snapshots four WIDTH-bit words on a load strobe, records their modular
//   sum, and streams the snapshot out as OUT_W-bit beats over valid/ready.
//   Word a goes first, most significant chunk of each word first.
//   Ports:
//     clock - rising-edge clock
//     reset - asynchronous, active-high reset (aborts any frame in flight)
//     bus   - quad_word_serializer_if.slave:
//             in_a..in_d  words to capture
//             load        capture request, ignored while busy
//             busy        high in SEND and DONE
//             out_data    current beat (top chunk of the shadow register)
//             out_valid   out_data is valid
//             out_ready   consumer accepts the beat this cycle
//             out_last    marks the final beat of a frame
//             checksum    modular sum of the captured words
//             done        one-cycle pulse after the final handshake
//             frame_count completed frames, wraps at 16 bits
module quad_word_serializer #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 8
) (
  input logic                   clock,
  input logic                   reset,
  quad_word_serializer_if.slave bus
);

  localparam int BEATS   = 4 * WIDTH / OUT_W;
  localparam int FRAME_W = 4 * WIDTH;
  localparam int CNT_W   = $clog2(BEATS);
  // Index of the beat before the final one: a handshake there makes the
  // next presented beat the last.
  localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(BEATS - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [FRAME_W-1:0] shift_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   checksum_r;
  logic [15:0]        frame_count_r;
  logic               valid_r;
  logic               last_r;
  logic               done_r;
  logic               busy_r;

  // Modular sum of the four captured words; carries out of WIDTH are dropped.
  function automatic logic [WIDTH-1:0] sum4(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] s;
    s = a + b;
    s = s + c;
    s = s + d;
    return s;
  endfunction

  // Frame state machine: capture, shift-out on handshake, done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      shift_r       <= '0;
      cnt_r         <= '0;
      checksum_r    <= '0;
      frame_count_r <= 16'd0;
      valid_r       <= 1'b0;
      last_r        <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.load) begin
            shift_r    <= {bus.in_a, bus.in_b, bus.in_c, bus.in_d};
            checksum_r <= sum4(bus.in_a, bus.in_b, bus.in_c, bus.in_d);
            cnt_r      <= '0;
            valid_r    <= 1'b1;
            last_r     <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (valid_r && bus.out_ready) begin
            // Shifting brings the next chunk to the top, which is out_data.
            shift_r <= {shift_r[FRAME_W-OUT_W-1:0], {OUT_W{1'b0}}};
            cnt_r   <= cnt_r + CNT_W'(1);
            if (last_r) begin
              valid_r       <= 1'b0;
              last_r        <= 1'b0;
              done_r        <= 1'b1;
              frame_count_r <= frame_count_r + 16'd1;
              state_r       <= ST_DONE;
            end else begin
              last_r <= (cnt_r == PENULT_IDX);
            end
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_data    = shift_r[FRAME_W-1 -: OUT_W];
  assign bus.out_valid   = valid_r;
  assign bus.out_last    = last_r;
  assign bus.checksum    = checksum_r;
  assign bus.done        = done_r;
  assign bus.frame_count = frame_count_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_quad_word_serializer.sv
// Self-checking bench for quad_word_serializer: table of directed frames,
// randomized frames against an arithmetic reference model, and a
// mid-frame reset sequence.
module tb_quad_word_serializer;
  localparam int WIDTH = 32;
  localparam int OUT_W = 8;
  localparam int BEATS = 16;

  logic        clock = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_fc;

  quad_word_serializer_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();

  quad_word_serializer #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a, b, c, d;
    int          mode;   // 0: ready high, 1: ready 1,0,0 repeating, 2: random
    bit          junk;   // pulse load with other data during SEND and DONE
    logic [31:0] cks;
    logic [7:0]  b0;
    logic [7:0]  b15;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Beat k of a frame: byte k counted from the most significant end.
  function automatic logic [7:0] model_beat(input logic [127:0] frame, input int k);
    logic [127:0] t;
    t = frame >> (8 * (BEATS - 1 - k));
    return t[7:0];
  endfunction

  function automatic logic [31:0] model_sum(input logic [31:0] a, b, c, d);
    logic [63:0] s;
    s = 64'(a) + 64'(b) + 64'(c) + 64'(d);
    return s[31:0];
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_data"}, bus.out_data, 0);
    check({tag, "_last"}, bus.out_last, 0);
    check({tag, "_cks"}, bus.checksum, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_fc"}, bus.frame_count, 0);
  endtask

  // Called and returning at a negedge with the DUT idle.
  task automatic run_frame(input logic [31:0] a, b, c, d, input int mode, input bit junk,
                           input logic [31:0] exp_cks, input logic [7:0] exp_b0,
                           input logic [7:0] exp_b15);
    logic [127:0] frame;
    int idx;
    int cyc;
    bit rdy;
    frame = {a, b, c, d};
    check("busy_before_load", bus.busy, 0);
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d;
    bus.load = 1'b1;
    bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    bus.load = 1'b0;
    check("checksum", bus.checksum, exp_cks);
    idx = 0;
    cyc = 0;
    while (idx < BEATS && cyc < 200) begin
      check("valid", bus.out_valid, 1);
      check("busy_send", bus.busy, 1);
      check("done_early", bus.done, 0);
      check("data", bus.out_data, model_beat(frame, idx));
      check("last", bus.out_last, (idx == BEATS - 1));
      if (idx == 0) check("beat_first", bus.out_data, exp_b0);
      if (idx == BEATS - 1) check("beat_final", bus.out_data, exp_b15);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      bus.out_ready = rdy;
      if (junk) begin
        bus.load = 1'($urandom_range(0, 1));
        bus.in_a = $urandom; bus.in_b = $urandom; bus.in_c = $urandom; bus.in_d = $urandom;
      end else begin
        bus.load = 1'b0;
      end
      if (rdy) idx++;
      cyc++;
      @(negedge clock);
    end
    bus.load = 1'b0;
    check("frame_beats", idx, BEATS);
    if (idx < BEATS) return;
    // DONE cycle
    exp_fc++;
    check("done_pulse", bus.done, 1);
    check("valid_in_done", bus.out_valid, 0);
    check("busy_in_done", bus.busy, 1);
    check("frame_count", bus.frame_count, exp_fc);
    check("checksum_hold", bus.checksum, exp_cks);
    bus.out_ready = 1'($urandom_range(0, 1));
    if (junk) begin
      bus.load = 1'b1;
      bus.in_a = ~a; bus.in_b = ~b; bus.in_c = $urandom; bus.in_d = $urandom;
    end
    @(negedge clock);
    bus.load = 1'b0;
    check("done_cleared", bus.done, 0);
    check("busy_idle", bus.busy, 0);
    check("valid_idle", bus.out_valid, 0);
    check("checksum_after", bus.checksum, exp_cks);
    check("frame_count_idle", bus.frame_count, exp_fc);
  endtask

  initial begin
    vecs[0] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 0, 1'b0, 32'hDE226598, 8'h11, 8'h00};
    vecs[1] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 1, 1'b0, 32'hDE226598, 8'h11, 8'h00};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 0, 1'b0, 32'h00000000, 8'hFF, 8'h00};
    vecs[3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 0, 1'b1, 32'hDE226598, 8'h11, 8'h00};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b1, 32'hFFFFFFFC, 8'hFF, 8'hFF};
    vecs[5] = '{32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0, 2, 1'b1, 32'hACF13567, 8'h12, 8'hF0};

    reset = 1'b1;
    bus.in_a = 32'd0; bus.in_b = 32'd0; bus.in_c = 32'd0; bus.in_d = 32'd0;
    bus.load = 1'b0;
    bus.out_ready = 1'b0;
    exp_fc = 16'd0;
    #12;
    check_zero("in_reset");
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("idle_valid", bus.out_valid, 0);
      check("idle_busy", bus.busy, 0);
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    check_zero("after_idle");

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].mode, vecs[i].junk,
                vecs[i].cks, vecs[i].b0, vecs[i].b15);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra, rb, rc, rd;
      ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
      run_frame(ra, rb, rc, rd, 2, 1'($urandom_range(0, 1)), model_sum(ra, rb, rc, rd),
                ra[31:24], rd[7:0]);
    end

    // Reset in the middle of a frame, after five accepted beats.
    bus.in_a = 32'hA1A2A3A4; bus.in_b = 32'hB1B2B3B4; bus.in_c = 32'hC1C2C3C4; bus.in_d = 32'hD1D2D3D4;
    bus.load = 1'b1;
    @(negedge clock);
    bus.load = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clock);
    check("pre_reset_beat5", bus.out_data, 8'hB2);
    #2;
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    exp_fc = 16'd0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post_reset_done", bus.done, 0);
      check("post_reset_valid", bus.out_valid, 0);
      @(negedge clock);
    end
    run_frame(vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].d, 0, 1'b0, vecs[0].cks, vecs[0].b0, vecs[0].b15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
